fifo_w1r2: RTL and testbench

Narrow-write / wide-read synchronous FIFO. Each accepted write stores one DATA_WIDTH word; each accepted read removes two words and presents them as one 2×DATA_WIDTH word. It is the read-wide counterpart of the team's write-wide (write-2/read-1) FIFO controller. It sits where a byte-serial producer feeds a consumer that processes word pairs. Pointers, flags and occupancy are kept here; storage is a dedicated sub-module.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_w1r2_regfile.sv | 30 +++
 rtl/fifo_w1r2.sv | 93 +++++++++
 tb/tb_fifo_w1r2.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the narrow-write / wide-read FIFO: default geometry,
// pointer/count types and the per-operation pointer steps.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;

    typedef logic [FIFO_ADDR_WIDTH-1:0] ptr_t;
    typedef logic [FIFO_ADDR_WIDTH:0]   cnt_t;

    localparam int RD_STEP = 2;
    localparam int WR_STEP = 1;

endpackage

// File: rtl/fifo_w1r2_regfile.sv
// Storage for fifo_w1r2: one synchronous write port and one combinational
// read port that returns the even/odd word pair starting at r_addr.
module reg_file_1w2r #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [ADDR_WIDTH-1:0]   r_addr,
    output logic [2*DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr_hi;

    // r_addr is always even, so the +1 never wraps past the top of the array.
    assign r_addr_hi = r_addr + 1'b1;
    assign r_data    = {mem_q[r_addr_hi], mem_q[r_addr]};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[w_addr] <= w_data;
        end
    end

endmodule

// File: rtl/fifo_w1r2.sv
// Write-1/read-2 FIFO control: show-ahead pair read, zero-latency flags from state.
// Full accepts a write alongside an accepted read; optional sticky err via FIFO_W1R2_ERR_EN.
module fifo_w1r2 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    rd,
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    empty,
    output logic                    full,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    err
);

    import fifo_pkg::*;

    localparam logic [ADDR_WIDTH:0]   DEPTH  = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   RD_INC = (ADDR_WIDTH+1)'(RD_STEP);
    localparam logic [ADDR_WIDTH:0]   WR_INC = (ADDR_WIDTH+1)'(WR_STEP);
    localparam logic [ADDR_WIDTH-1:0] RP_INC = ADDR_WIDTH'(RD_STEP);
    localparam logic [ADDR_WIDTH-1:0] WP_INC = ADDR_WIDTH'(WR_STEP);

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  rd_ok, wr_ok;

    assign rd_ok = rd & (count_q >= RD_INC);
    assign wr_ok = wr & ((count_q < DEPTH) | rd_ok);

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q + (wr_ok ? WR_INC : '0) - (rd_ok ? RD_INC : '0);
        if (wr_ok) begin
            w_ptr_d = w_ptr_q + WP_INC;
        end
        if (rd_ok) begin
            r_ptr_d = r_ptr_q + RP_INC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
        end
    end

`ifdef FIFO_W1R2_ERR_EN
    logic err_q, err_d;

    assign err_d = err_q | (rd & ~rd_ok) | (wr & ~wr_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign count = count_q;
    assign empty = (count_q < RD_INC);
    assign full  = (count_q == DEPTH);

    reg_file_1w2r #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_ok),
        .w_addr (w_ptr_q),
        .w_data (w_data),
        .r_addr (r_ptr_q),
        .r_data (r_data)
    );

endmodule

// File: tb/tb_fifo_w1r2.sv
// Directed bench for fifo_w1r2 (D=16); err expectations follow FIFO_W1R2_ERR_EN.
module tb_fifo_w1r2;

`ifdef FIFO_W1R2_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic [7:0]  w_data;
    logic        rd;
    logic [15:0] r_data;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_w1r2 #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .w_data (w_data),
        .rd     (rd),
        .r_data (r_data),
        .empty  (empty),
        .full   (full),
        .count  (count),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [4:0] c, input logic e,
                               input logic f, input logic er);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".empty"}, 32'(empty), 32'(e));
        check({tag, ".full"},  32'(full),  32'(f));
        check({tag, ".err"},   32'(err),   32'(er));
    endtask

    task automatic push(input logic [7:0] d);
        wr = 1'b1; w_data = d; tick(); wr = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [15:0] exp);
        check(tag, 32'(r_data), 32'(exp));
        rd = 1'b1; tick(); rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0; #1;
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
        tick();
        check_flags("in_reset", 5'd0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); tick();
        check_flags("idle", 5'd0, 1'b1, 1'b0, 1'b0);

        // single pair: one word is not readable, two are
        push(8'h11);
        check_flags("one_word", 5'd1, 1'b1, 1'b0, 1'b0);
        push(8'h22);
        check_flags("two_words", 5'd2, 1'b0, 1'b0, 1'b0);
        pop_check("pair_2211", 16'h2211);
        check_flags("after_pop", 5'd0, 1'b1, 1'b0, 1'b0);

        // fill from w_ptr=2 so the wrap of both pointers is crossed
        for (int i = 0; i < 16; i++) push(8'(i));
        check_flags("full", 5'd16, 1'b0, 1'b1, 1'b0);
        push(8'h99);
        check_flags("overflow", 5'd16, 1'b0, 1'b1, ERR_EN);
        for (int i = 0; i < 8; i++)
            pop_check("drain", {8'(2*i+1), 8'(2*i)});
        check_flags("drained", 5'd0, 1'b1, 1'b0, ERR_EN);

        // full with simultaneous read and write, write lands at wrapped w_ptr=0
        do_reset();
        check_flags("reset2", 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
        check_flags("full2", 5'd16, 1'b0, 1'b1, 1'b0);
        check("rw_pair", 32'(r_data), 32'h3130);
        rd = 1'b1; wr = 1'b1; w_data = 8'hAA; tick(); rd = 1'b0; wr = 1'b0;
        check_flags("rw_full", 5'd15, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++)
            pop_check("drain2", {8'h31 + 8'(2*i), 8'h30 + 8'(2*i)});
        check_flags("one_left", 5'd1, 1'b1, 1'b0, 1'b0);

        // underflow attempt with a single word stored
        rd = 1'b1; tick(); rd = 1'b0;
        check_flags("underflow", 5'd1, 1'b1, 1'b0, ERR_EN);
        push(8'hBB);
        check("wrap_pair", 32'(r_data), 32'hBBAA);
        rd = 1'b1; tick(); rd = 1'b0;
        check_flags("wrap_popped", 5'd0, 1'b1, 1'b0, ERR_EN);

        // asynchronous reset in the middle of a stream
        do_reset();
        for (int i = 0; i < 10; i++) push(8'h50 + 8'(i));
        pop_check("mid0", 16'h5150);
        pop_check("mid1", 16'h5352);
        pop_check("mid2", 16'h5554);
        check_flags("mid_cnt", 5'd4, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_flags("async_rst", 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        push(8'h61);
        push(8'h62);
        check("post_rst_pair", 32'(r_data), 32'h6261);
        rd = 1'b1; tick(); rd = 1'b0;
        check_flags("post_rst_pop", 5'd0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
